// File: rtl/reqack_fifo_stage_if.sv
// Handshake bundle for reqack_fifo_stage.
//   prod_req/prod_ack/prod_dat : upstream four-phase channel (stage acks)
//   cons_req/cons_ack/cons_dat : downstream four-phase channel (stage requests)
//   count                      : FIFO occupancy, 0..DEPTH
// slave  : the stage itself.
// master : the environment around it (producer and consumer).
interface reqack_fifo_stage_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
);
  localparam int AWIDTH = $clog2(DEPTH);

  logic              prod_req;
  logic              prod_ack;
  logic [DWIDTH-1:0] prod_dat;
  logic              cons_req;
  logic              cons_ack;
  logic [DWIDTH-1:0] cons_dat;
  logic [AWIDTH:0]   count;

  modport master (
    output prod_req, prod_dat, cons_ack,
    input  prod_ack, cons_req, cons_dat, count
  );

  modport slave (
    input  prod_req, prod_dat, cons_ack,
    output prod_ack, cons_req, cons_dat, count
  );
endinterface

// File: rtl/reqack_fifo_stage.sv
// Buffered four-phase req/ack pipeline stage.
// The producer is acked as soon as a slot is free; the consumer is fed
// entries in strict FIFO order, one per four-phase cycle. Both incoming
// handshake lines (prod_req, cons_ack) are asynchronous and pass through
// two-flop synchronizers before use.
// Ports:
//   clk  : stage clock
//   rst  : synchronous reset, active-high
//   bus  : reqack_fifo_stage_if.slave (producer/consumer channels + count)
module reqack_fifo_stage #(
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 4,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  reqack_fifo_stage_if.slave  bus
);

  localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(DEPTH);

  logic [1:0]        req_pipe, ack_pipe;
  logic              sreq, sack;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wptr, rptr;
  logic [AWIDTH:0]   cnt;
  logic              prod_ack_q, cons_req_q;
  logic [DWIDTH-1:0] cons_dat_q;
  logic              push, pop;

  assign sreq = req_pipe[1];
  assign sack = ack_pipe[1];

  // One word per producer four-phase cycle: prod_ack must return to 0
  // before another push can be taken. A full FIFO just holds the request.
  assign push = sreq & ~prod_ack_q & (cnt != FULL);
  // The consumer must have returned its ack to zero before the next word.
  assign pop  = ~cons_req_q & ~sack & (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pipe   <= '0;
      ack_pipe   <= '0;
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      prod_ack_q <= 1'b0;
      cons_req_q <= 1'b0;
      cons_dat_q <= '0;
    end else begin
      req_pipe <= {req_pipe[0], bus.prod_req};
      ack_pipe <= {ack_pipe[0], bus.cons_ack};

      if (push) begin
        wptr       <= wptr + AWIDTH'(1);
        prod_ack_q <= 1'b1;
      end else if (!sreq && prod_ack_q) begin
        prod_ack_q <= 1'b0;
      end

      // Read comes from registered storage, so a word pushed this cycle
      // can only be popped from the next cycle on.
      if (pop) begin
        cons_dat_q <= mem[rptr];
        rptr       <= rptr + AWIDTH'(1);
        cons_req_q <= 1'b1;
      end else if (cons_req_q && sack) begin
        cons_req_q <= 1'b0;
      end

      cnt <= cnt + (AWIDTH+1)'(push) - (AWIDTH+1)'(pop);
    end
  end

  // Storage is not reset; entries become meaningful only through wptr/cnt.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= bus.prod_dat;
  end

  assign bus.prod_ack = prod_ack_q;
  assign bus.cons_req = cons_req_q;
  assign bus.cons_dat = cons_dat_q;
  assign bus.count    = cnt;

endmodule

// File: tb/tb_reqack_fifo_stage.sv
module tb_reqack_fifo_stage;
  logic clk, rst;
  logic auto_mode, auto_ack, man_ack;
  int   total, bad, rx_cnt;
  logic [7:0] last_rx;
  logic [7:0] q[$];
  int   dly;

  reqack_fifo_stage_if #(.DWIDTH(8), .DEPTH(4)) bus();

  reqack_fifo_stage #(.DWIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.cons_ack = auto_mode ? auto_ack : man_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic wait_ack(input logic v, input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.prod_ack === v) return;
    end
    timeout(nm);
  endtask

  task automatic wait_creq(input logic v, input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cons_req === v) return;
    end
    timeout(nm);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.count == 0 && q.size() == 0 && bus.cons_req === 1'b0) return;
    end
    timeout(nm);
  endtask

  // Full producer four-phase cycle; expected data is queued at issue.
  task automatic produce(input logic [7:0] d);
    bus.prod_dat = d;
    bus.prod_req = 1'b1;
    q.push_back(d);
    wait_ack(1'b1, "push_ack");
    bus.prod_req = 1'b0;
    wait_ack(1'b0, "push_rtz");
  endtask

  // Auto consumer: random delay before ack, drops ack after cons_req falls.
  initial begin
    auto_ack = 1'b0;
    dly = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!auto_mode) auto_ack = 1'b0;
      else if (bus.cons_req && !auto_ack) begin
        if (dly == 0) begin
          auto_ack = 1'b1;
          dly = $urandom_range(0, 5);
        end else dly--;
      end else if (!bus.cons_req && auto_ack) auto_ack = 1'b0;
    end
  end

  // Monitor: every rising cons_req is one delivered word.
  initial begin
    logic prev;
    logic [7:0] exp;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cons_req === 1'b1 && !prev) begin
        rx_cnt++;
        last_rx = bus.cons_dat;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected: got %0h expected none", bus.cons_dat);
        end else begin
          exp = q.pop_front();
          if (bus.cons_dat !== exp) begin
            bad++;
            $display("FAIL rx_data: got %0h expected %0h", bus.cons_dat, exp);
          end
        end
      end
      prev = (bus.cons_req === 1'b1);
    end
  end

  initial begin
    total = 0; bad = 0; rx_cnt = 0; last_rx = '0;
    rst = 1'b1;
    auto_mode = 1'b0;
    man_ack = 1'b1;
    bus.prod_req = 1'b1;
    bus.prod_dat = 8'h00;

    // Reset held with both handshake inputs high.
    repeat (2) begin
      @(negedge clk);
      chk("rst_prod_ack", bus.prod_ack, 0);
      chk("rst_cons_req", bus.cons_req, 0);
      chk("rst_cons_dat", bus.cons_dat, 0);
      chk("rst_count", bus.count, 0);
    end
    rst = 1'b0;
    bus.prod_req = 1'b0;
    man_ack = 1'b0;
    repeat (4) @(negedge clk);

    // Single transfer latency.
    @(posedge clk); #1;
    bus.prod_dat = 8'hA5;
    bus.prod_req = 1'b1;
    q.push_back(8'hA5);
    @(posedge clk);                 // E0
    @(posedge clk);                 // E1
    @(negedge clk);
    chk("lat_ack_e1", bus.prod_ack, 0);
    @(negedge clk);                 // after E2
    chk("lat_ack_e2", bus.prod_ack, 1);
    chk("lat_count_e2", bus.count, 1);
    chk("lat_creq_e2", bus.cons_req, 0);
    @(negedge clk);                 // after E3
    chk("lat_creq_e3", bus.cons_req, 1);
    chk("lat_dat_e3", bus.cons_dat, 8'hA5);
    chk("lat_count_e3", bus.count, 0);
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("creq_rtz", bus.cons_req, 0);
    bus.prod_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("ack_rtz", bus.prod_ack, 0);
    man_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Full stall: consumer idle with ack held high.
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 4; i++) produce(8'(i));
    chk("full_count", bus.count, 4);
    bus.prod_dat = 8'h05;
    bus.prod_req = 1'b1;
    q.push_back(8'h05);
    repeat (10) @(negedge clk);
    chk("full_hold_ack", bus.prod_ack, 0);
    chk("full_hold_count", bus.count, 4);
    man_ack = 1'b0;
    wait_creq(1'b1, "full_pop");
    chk("full_after_pop", bus.count, 3);
    man_ack = 1'b1;
    wait_ack(1'b1, "full_late_ack");
    chk("full_refill", bus.count, 4);
    bus.prod_req = 1'b0;
    wait_ack(1'b0, "full_rtz");
    wait_creq(1'b0, "full_creq_rtz");
    auto_mode = 1'b1;
    wait_drain("full_drain");

    // Push and pop landing on the same edge at count=2.
    auto_mode = 1'b0;
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    produce(8'h21);
    produce(8'h22);
    chk("sim_count_pre", bus.count, 2);
    bus.prod_dat = 8'h23;
    bus.prod_req = 1'b1;
    man_ack = 1'b0;
    q.push_back(8'h23);
    repeat (2) @(negedge clk);
    chk("sim_ack_pre", bus.prod_ack, 0);
    chk("sim_creq_pre", bus.cons_req, 0);
    @(negedge clk);
    chk("sim_count_post", bus.count, 2);
    chk("sim_ack_post", bus.prod_ack, 1);
    chk("sim_creq_post", bus.cons_req, 1);
    bus.prod_req = 1'b0;
    man_ack = 1'b1;
    wait_ack(1'b0, "sim_rtz");
    wait_creq(1'b0, "sim_creq_rtz");
    auto_mode = 1'b1;
    wait_drain("sim_drain");

    // Wrap-around streaming with a random-delay consumer.
    for (int i = 0; i < 10; i++) produce(8'h10 + 8'(i));
    wait_drain("wrap_drain");
    chk("wrap_count", bus.count, 0);
    chk("wrap_last", last_rx, 8'h19);

    // Reset in the middle of operation.
    auto_mode = 1'b0;
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 4; i++) produce(8'h40 + 8'(i));
    man_ack = 1'b0;
    wait_creq(1'b1, "mid_pop");
    chk("mid_count", bus.count, 3);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_creq", bus.cons_req, 0);
    chk("mid_rst_dat", bus.cons_dat, 0);
    rst = 1'b0;
    rx_cnt = 0;
    auto_mode = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_stale", rx_cnt, 0);
    produce(8'h77);
    wait_drain("mid_drain");
    chk("mid_rx_cnt", rx_cnt, 1);
    chk("mid_first", last_rx, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
